// File: rtl/aes_128_arb.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_arb
// Purpose  : Shares one fixed-latency, non-stalling aes_128 core between two
//            requesters. Round-robin grant, per-requester response FIFOs and
//            credit-based admission so that no core result is ever dropped.
// Options  : AES_ARB_PERF_EN adds saturating grant/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module aes_128_arb #(
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_state,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_state,
  input  logic [127:0] req1_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic         busy
`ifdef AES_ARB_PERF_EN
  ,
  output logic [31:0]  perf_grant0,
  output logic [31:0]  perf_grant1,
  output logic [31:0]  perf_stall
`endif
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_pinc  = c_ptr_w'(1);

  // Arbitration
  logic [1:0] w_valid;
  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic       r_ptr;      // 0: requester 0 wins a tie, 1: requester 1 wins

  // Core launch registers
  logic [127:0] r_core_state;
  logic [127:0] r_core_key;

  // Tag pipeline: index 0 launches with the core registers, index LATENCY
  // lines up with the core_out word produced from that launch.
  logic [LATENCY:0] r_tag_v;
  logic [LATENCY:0] r_tag_id;

  // Per-requester credit and response FIFO state
  logic [c_cnt_w-1:0] r_credit [2];
  logic [c_cnt_w-1:0] r_cnt    [2];
  logic [c_ptr_w-1:0] r_wptr   [2];
  logic [c_ptr_w-1:0] r_rptr   [2];
  logic [127:0]       r_mem    [2][FIFO_DEPTH];

  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_rsp_ready;
  logic [1:0] w_rsp_valid;

  // Eligibility, round-robin grant, FIFO push/pop strobes
  always_comb begin
    w_valid     = {req1_valid, req0_valid};
    w_rsp_ready = {rsp1_ready, rsp0_ready};
    w_elig      = 2'b00;
    w_grant     = 2'b00;
    w_rsp_valid = 2'b00;
    w_pop       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_elig[i]      = w_valid[i] && (r_credit[i] != '0);
      w_rsp_valid[i] = (r_cnt[i] != '0);
      w_pop[i]       = w_rsp_valid[i] && w_rsp_ready[i];
    end
    if (!rst) begin
      if (w_elig[0] && (!w_elig[1] || !r_ptr)) begin
        w_grant[0] = 1'b1;
      end else if (w_elig[1]) begin
        w_grant[1] = 1'b1;
      end
    end
    w_push[0] = r_tag_v[LATENCY] && !r_tag_id[LATENCY];
    w_push[1] = r_tag_v[LATENCY] &&  r_tag_id[LATENCY];
  end

  // Round-robin pointer: after a grant, favour the other requester
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_grant[0]) begin
      r_ptr <= 1'b1;
    end else if (w_grant[1]) begin
      r_ptr <= 1'b0;
    end
  end

  // Core operand registers load the winner's block, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_state <= '0;
      r_core_key   <= '0;
    end else if (w_grant[0]) begin
      r_core_state <= req0_state;
      r_core_key   <= req0_key;
    end else if (w_grant[1]) begin
      r_core_state <= req1_state;
      r_core_key   <= req1_key;
    end
  end

  // Tag pipeline tracks which requester owns each core slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0],  |w_grant};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_grant[1]};
    end
  end

  // Credits, FIFO pointers and occupancy per requester
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_credit[i] <= c_depth;
        r_cnt[i]    <= '0;
        r_wptr[i]   <= '0;
        r_rptr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Accept consumes a credit, pop returns one; both together cancel.
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - c_one;
          2'b01:   r_credit[i] <= r_credit[i] + c_one;
          default: r_credit[i] <= r_credit[i];
        endcase
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + c_one;
          2'b01:   r_cnt[i] <= r_cnt[i] - c_one;
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + c_pinc;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + c_pinc;
        end
      end
    end
  end

  // FIFO storage; credits guarantee a push never lands on a full FIFO
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= core_out;
      end
    end
  end

`ifdef AES_ARB_PERF_EN
  logic [31:0] r_perf_g0;
  logic [31:0] r_perf_g1;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (req0_valid && !w_grant[0]) || (req1_valid && !w_grant[1]);

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_g0    <= '0;
      r_perf_g1    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_grant[0] && (r_perf_g0 != '1)) begin
        r_perf_g0 <= r_perf_g0 + 32'd1;
      end
      if (w_grant[1] && (r_perf_g1 != '1)) begin
        r_perf_g1 <= r_perf_g1 + 32'd1;
      end
      if (w_stall && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_grant0 = r_perf_g0;
  assign perf_grant1 = r_perf_g1;
  assign perf_stall  = r_perf_stall;
`endif

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign core_state = r_core_state;
  assign core_key   = r_core_key;
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_data  = r_mem[0][r_rptr[0]];
  assign rsp1_data  = r_mem[1][r_rptr[1]];
  assign busy       = (|r_tag_v) || w_rsp_valid[0] || w_rsp_valid[1];

endmodule
`default_nettype wire

// File: tb/tb_aes_128_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_arb
// Purpose  : Self-checking bench for aes_128_arb with a fixed-latency core
//            model (known AES vectors, XOR for everything else).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_128_arb;

  localparam int LATENCY    = 20;
  localparam int FIFO_DEPTH = 4;

  localparam logic [127:0] c_fips_pt = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_fips_k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_fips_ct = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_appc_pt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_appc_k  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_appc_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_state, req0_key, req1_state, req1_key;
  logic [127:0] core_state, core_key, core_out;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [127:0] rsp0_data, rsp1_data;
  logic         busy;
`ifdef AES_ARB_PERF_EN
  logic [31:0]  perf_grant0, perf_grant1, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_128_arb #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
`ifdef AES_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Stand-in for the aes_128 core: known vectors, otherwise state ^ key
  function automatic logic [127:0] core_model(input logic [127:0] s, input logic [127:0] k);
    if (s == c_fips_pt && k == c_fips_k) return c_fips_ct;
    if (s == c_appc_pt && k == c_appc_k) return c_appc_ct;
    return s ^ k;
  endfunction

  // Core pipeline: output follows core_state/core_key by LATENCY edges
  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_model(core_state, core_key);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected ciphertexts queued at accept, checked at pop
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];

  task automatic sb_pop(input int side, input logic [127:0] data);
    logic [127:0] e;
    n_checks++;
    if ((side == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      n_fail++;
      $display("FAIL sb_rsp%0d_unexpected: got %h, expected no response", side, data);
    end else begin
      e = (side == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (data !== e) begin
        n_fail++;
        $display("FAIL sb_rsp%0d_data: got %h, expected %h", side, data, e);
      end
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) exp_q0.push_back(core_model(req0_state, req0_key));
      if (req1_valid && req1_ready) exp_q1.push_back(core_model(req1_state, req1_key));
      if (rsp0_valid && rsp0_ready) sb_pop(0, rsp0_data);
      if (rsp1_valid && rsp1_ready) sb_pop(1, rsp1_data);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         side;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin : g_global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, acc0, acc1, bad;
    logic got, other_seen;

    vecs[0] = '{side: 1'b0, state: c_fips_pt, key: c_fips_k, exp: c_fips_ct};
    vecs[1] = '{side: 1'b1, state: c_appc_pt, key: c_appc_k, exp: c_appc_ct};
    vecs[2] = '{side: 1'b0, state: 128'h1, key: 128'h2, exp: 128'h3};
    vecs[3] = '{side: 1'b1, state: 128'h0123456789abcdef0123456789abcdef,
                key: 128'hffffffffffffffffffffffffffffffff,
                exp: 128'hfedcba9876543210fedcba9876543210};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_state = '0; req0_key = '0; req1_state = '0; req1_key = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset: ready must stay low even with valid requests
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #4 check("ready_in_reset", 128'({req1_ready, req0_ready}), 128'd0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #4;
    check("reset_core_state", core_state, 128'd0);
    check("reset_core_key", core_key, 128'd0);
    check("reset_outputs", 128'({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}), 128'd0);

    // Table: single blocks, latency and data per requester
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      if (vecs[v].side) begin
        req1_valid = 1'b1; req1_state = vecs[v].state; req1_key = vecs[v].key;
      end else begin
        req0_valid = 1'b1; req0_state = vecs[v].state; req0_key = vecs[v].key;
      end
      #4 check($sformatf("vec%0d_accept", v), 128'(vecs[v].side ? req1_ready : req0_ready), 128'd1);
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      cyc = 0; got = 1'b0; other_seen = 1'b0;
      while (!got && cyc < 3 * LATENCY) begin
        @(posedge clk);
        cyc++;
        #1;
        if (vecs[v].side ? rsp0_valid : rsp1_valid) other_seen = 1'b1;
        if (vecs[v].side ? rsp1_valid : rsp0_valid) got = 1'b1;
      end
      check($sformatf("vec%0d_latency", v), 128'(cyc), 128'(LATENCY + 1));
      check($sformatf("vec%0d_data", v), vecs[v].side ? rsp1_data : rsp0_data, vecs[v].exp);
      check($sformatf("vec%0d_other_idle", v), 128'(other_seen), 128'd0);
      repeat (2) @(negedge clk);
    end

    // Contention: grants alternate 0,1,0,1; per-requester order kept
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_state = c_fips_pt; req0_key = c_fips_k;
        req1_valid = 1'b1; req1_state = c_appc_pt; req1_key = c_appc_k;
      end
      if (i == 2) begin
        req0_state = vecs[3].state; req0_key = vecs[3].key;
      end
      #4 check($sformatf("contend_grant%0d", i), 128'({req1_ready, req0_ready}),
               (i % 2 == 0) ? 128'd1 : 128'd2);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (LATENCY + 6) @(negedge clk);
    #4;
    check("contend_drain_q0", 128'(exp_q0.size()), 128'd0);
    check("contend_drain_q1", 128'(exp_q1.size()), 128'd0);
    check("contend_busy", 128'(busy), 128'd0);

    // Backpressure on requester 0 while requester 1 keeps draining
    do_reset();
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_state = 128'(i); req0_key = 128'h1;
      req1_valid = 1'b1; req1_state = {96'hbeef, 32'(i)}; req1_key = 128'h5;
      #4;
      acc0 += int'(req0_ready);
      acc1 += int'(req1_ready);
    end
    check("bp_accepts0", 128'(acc0), 128'd4);
    check("bp_accepts1", 128'(acc1), 128'd8);
    @(negedge clk);
    req1_valid = 1'b0;
    #4;
    check("bp_credit_exhausted", 128'(req0_ready), 128'd0);
    check("bp_fifo0_valid", 128'(rsp0_valid), 128'd1);
    acc0 = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      rsp0_ready = (j == 0);
      req0_state = 128'(100 + j);
      #4 acc0 += int'(req0_ready);
    end
    check("bp_one_pop_one_accept", 128'(acc0), 128'd1);

    // Sustained push/pop with the FIFO at capacity; no loss or duplication
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      rsp0_ready = 1'b1;
      req0_state = 128'(200 + j);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (LATENCY + 8) @(negedge clk);
    #4;
    check("full_drain_q0", 128'(exp_q0.size()), 128'd0);
    check("full_drain_q1", 128'(exp_q1.size()), 128'd0);
    check("full_drain_idle", 128'({busy, rsp0_valid}), 128'd0);

    // Reset with three blocks in flight
    do_reset();
    acc0 = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_state = 128'(300 + j);
      #4 acc0 += int'(req0_ready);
    end
    check("mid_accepts", 128'(acc0), 128'd3);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #4 check("mid_busy", 128'(busy), 128'd0);
    bad = 0;
    repeat (2 * LATENCY) begin
      @(negedge clk);
      #4 if (rsp0_valid || rsp1_valid) bad++;
    end
    check("mid_no_rsp", 128'(bad), 128'd0);
    acc0 = 0; acc1 = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #4;
      if (j == 0) check("mid_first_grant", 128'({req1_ready, req0_ready}), 128'd1);
      acc0 += int'(req0_ready);
      acc1 += int'(req1_ready);
    end
    check("mid_credit0", 128'(acc0), 128'd4);
    check("mid_credit1", 128'(acc1), 128'd4);

`ifdef AES_ARB_PERF_EN
    // Eight contested cycles: four grants each, one loser every cycle
    do_reset();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #4;
    check("perf_grant0", 128'(perf_grant0), 128'd4);
    check("perf_grant1", 128'(perf_grant1), 128'd4);
    check("perf_stall", 128'(perf_stall), 128'd8);
`endif

    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
